// File: rtl/chameleon2_pkg.sv
// Shared definitions for the Chameleon2 serial-output chain driver.
//   ser_state_t    : transfer FSM states
//   SER_*_RST      : idle/reset levels of the ser_out_* pins; the top level
//                    uses the same values to tie the pins off when the
//                    shifter block is not instantiated.
package chameleon2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIT_LO,
        BIT_HI,
        LATCH_LO,
        LATCH_HI
    } ser_state_t;

    localparam logic SER_CLK_RST  = 1'b0;
    localparam logic SER_DAT_RST  = 1'b0;
    localparam logic SER_RCLK_RST = 1'b1;

endpackage

// File: rtl/clk_prescaler.sv
// Divide-by-CLKDIV tick generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous restart of the count (state entry)
//   tick  : high in the last cycle of each CLKDIV-cycle period
module clk_prescaler #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLKDIV + 1);

    logic [CW-1:0] count;

    assign tick = (count == CW'(CLKDIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/ser_out_shifter.sv
// Driver for a 74HC595-style serial shift/latch chain.
// Shifts a WIDTH-bit word out at CLKDIV cycles per half bit, then pulses the
// latch clock. Loads arriving mid-transfer coalesce into one follow-up
// transfer of the newest data_in.
//   clk50m, reset_n : clock, asynchronous active-low reset
//   data_in, load   : word to send, single-cycle transfer request
//   busy, done      : transfer in progress, one-cycle latch-issued pulse
//   ser_out_clk/dat/rclk : chain shift clock, serial data, latch clock
module ser_out_shifter
    import chameleon2_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CLKDIV      = 4,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit AUTO_UPDATE = 1'b0
) (
    input  logic             clk50m,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             ser_out_clk,
    output logic             ser_out_dat,
    output logic             ser_out_rclk
);

    localparam int BW = $clog2(WIDTH + 1);

    ser_state_t       state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [WIDTH-1:0] cap, cap_d;
    logic [WIDTH-1:0] last, last_d;
    logic [BW-1:0]    bitcnt, bitcnt_d;
    logic             pending, pending_d;
    logic             tick, clr;
    logic             start;
    logic             head_d;

    // Prescaler restarts on every state entry, so each timed state lasts
    // exactly CLKDIV cycles.
    assign clr = (state_d != state) || (state == IDLE);

    clk_prescaler #(.CLKDIV(CLKDIV)) u_presc (
        .clk   (clk50m),
        .rst_n (reset_n),
        .clr   (clr),
        .tick  (tick)
    );

    assign start = load || (AUTO_UPDATE && (data_in != last));

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        cap_d     = cap;
        last_d    = last;
        bitcnt_d  = bitcnt;
        pending_d = pending;

        // Only explicit loads are remembered; an auto-update change is judged
        // at the latch by comparing against the captured word, so a value
        // that changes and changes back costs no extra transfer.
        if (state != IDLE && load)
            pending_d = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = BIT_LO;
                    shreg_d   = data_in;
                    cap_d     = data_in;
                    bitcnt_d  = BW'(WIDTH);
                    pending_d = 1'b0;
                end
            end
            BIT_LO: begin
                if (tick)
                    state_d = BIT_HI;
            end
            BIT_HI: begin
                if (tick) begin
                    shreg_d  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    bitcnt_d = (bitcnt != '0) ? bitcnt - 1'b1 : '0;
                    state_d  = (bitcnt <= BW'(1)) ? LATCH_LO : BIT_LO;
                end
            end
            LATCH_LO: begin
                if (tick)
                    state_d = LATCH_HI;
            end
            LATCH_HI: begin
                last_d    = cap;
                pending_d = 1'b0;
                if (pending || load || (AUTO_UPDATE && (data_in != cap))) begin
                    state_d  = BIT_LO;
                    shreg_d  = data_in;
                    cap_d    = data_in;
                    bitcnt_d = BW'(WIDTH);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign head_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cap     <= '0;
            last    <= '0;
            bitcnt  <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            cap     <= cap_d;
            last    <= last_d;
            bitcnt  <= bitcnt_d;
            pending <= pending_d;
        end
    end

    // Pins are registered from the next-state decode so they are glitch-free
    // yet still track the state register cycle for cycle.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            ser_out_clk  <= SER_CLK_RST;
            ser_out_dat  <= SER_DAT_RST;
            ser_out_rclk <= SER_RCLK_RST;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            ser_out_clk  <= (state_d == BIT_HI);
            ser_out_dat  <= ((state_d == BIT_LO) || (state_d == BIT_HI)) ? head_d : 1'b0;
            ser_out_rclk <= (state_d != LATCH_LO);
            busy         <= (state_d != IDLE);
            done         <= (state_d == LATCH_HI);
        end
    end

endmodule

// File: tb/tb_ser_out_shifter.sv
// Bench for ser_out_shifter: four configurations share one clock.
//   u0: WIDTH16 CLKDIV4 MSB-first   (latency, coalescing, reset abort)
//   u1: WIDTH16 CLKDIV4 LSB-first
//   u2: WIDTH16 CLKDIV4 MSB-first AUTO_UPDATE
//   u3: WIDTH1  CLKDIV1
// A 74HC595 chain model per instance shifts on ser_out_clk rise and latches
// on ser_out_rclk rise; expected latched words sit in a scoreboard queue.
module tb_ser_out_shifter;

    logic        clk = 1'b0;
    logic        rstn, rst0;
    logic [3:0]  load;
    logic [15:0] din [4];
    logic [3:0]  busy, done, sclk, sdat, srclk;

    int checks = 0;
    int errors = 0;

    logic [15:0] expq[$];
    int          exp_lat [4] = '{default: 0};

    // chain model state, written only by the monitor
    logic [15:0] chain [4]         = '{default: 16'h0};
    logic [15:0] lat_word [4]      = '{default: 16'h0};
    int          clk_since [4]     = '{default: 0};
    int          bits_at_latch [4] = '{default: 0};
    int          lat_cnt [4]       = '{default: 0};
    logic        firstbit [4]      = '{default: 1'b0};
    logic [3:0]  psclk = 4'h0, psrclk = 4'hF;

    always #5 clk = ~clk;

    ser_out_shifter #(.WIDTH(16), .CLKDIV(4), .MSB_FIRST(1'b1), .AUTO_UPDATE(1'b0)) u0 (
        .clk50m(clk), .reset_n(rst0), .data_in(din[0]), .load(load[0]),
        .busy(busy[0]), .done(done[0]), .ser_out_clk(sclk[0]),
        .ser_out_dat(sdat[0]), .ser_out_rclk(srclk[0]));

    ser_out_shifter #(.WIDTH(16), .CLKDIV(4), .MSB_FIRST(1'b0), .AUTO_UPDATE(1'b0)) u1 (
        .clk50m(clk), .reset_n(rstn), .data_in(din[1]), .load(load[1]),
        .busy(busy[1]), .done(done[1]), .ser_out_clk(sclk[1]),
        .ser_out_dat(sdat[1]), .ser_out_rclk(srclk[1]));

    ser_out_shifter #(.WIDTH(16), .CLKDIV(4), .MSB_FIRST(1'b1), .AUTO_UPDATE(1'b1)) u2 (
        .clk50m(clk), .reset_n(rstn), .data_in(din[2]), .load(load[2]),
        .busy(busy[2]), .done(done[2]), .ser_out_clk(sclk[2]),
        .ser_out_dat(sdat[2]), .ser_out_rclk(srclk[2]));

    ser_out_shifter #(.WIDTH(1), .CLKDIV(1), .MSB_FIRST(1'b1), .AUTO_UPDATE(1'b0)) u3 (
        .clk50m(clk), .reset_n(rstn), .data_in(din[3][0:0]), .load(load[3]),
        .busy(busy[3]), .done(done[3]), .ser_out_clk(sclk[3]),
        .ser_out_dat(sdat[3]), .ser_out_rclk(srclk[3]));

    // Chain model: sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sclk[i] && !psclk[i]) begin
                if (clk_since[i] == 0)
                    firstbit[i] <= sdat[i];
                chain[i]     <= {chain[i][14:0], sdat[i]};
                clk_since[i] <= clk_since[i] + 1;
            end else if (srclk[i] && !psrclk[i]) begin
                lat_word[i]      <= (i == 3) ? {15'h0, chain[i][0]} : chain[i];
                bits_at_latch[i] <= clk_since[i];
                lat_cnt[i]       <= lat_cnt[i] + 1;
                clk_since[i]     <= 0;
            end else if (!busy[i]) begin
                clk_since[i] <= 0;
            end
        end
        psclk  <= sclk;
        psrclk <= srclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int b = 0; b < 16; b++)
            r[b] = v[15-b];
        return r;
    endfunction

    // Drive a one-cycle load; returns at the falling edge of the first busy cycle.
    task automatic do_load(input int i, input logic [15:0] d, input bit push);
        @(negedge clk);
        din[i]  = d;
        load[i] = 1'b1;
        if (push)
            expq.push_back(d);
        @(negedge clk);
        load[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < limit);
    endtask

    // Pop the scoreboard and compare against what the chain model latched.
    task automatic check_xfer(input int i, input int w);
        logic [15:0] e;
        chk("sb_has_entry", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("latched_word", 32'(lat_word[i]), 32'(e));
        end
        chk("shift_edges", 32'(bits_at_latch[i]), 32'(w));
        exp_lat[i]++;
        chk("latch_count", 32'(lat_cnt[i]), 32'(exp_lat[i]));
    endtask

    initial begin
        int n, hi, lc;
        rstn = 1'b0;
        rst0 = 1'b0;
        load = 4'h0;
        for (int i = 0; i < 4; i++)
            din[i] = 16'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_clk",  32'(sclk),  32'h0);
        chk("rst_dat",  32'(sdat),  32'h0);
        chk("rst_rclk", 32'(srclk), 32'hF);
        chk("rst_busy", 32'(busy),  32'h0);
        chk("rst_done", 32'(done),  32'h0);
        rstn = 1'b1;
        rst0 = 1'b1;
        repeat (2) @(negedge clk);

        // MSB-first A5C3, latency
        do_load(0, 16'hA5C3, 1'b1);
        wait_done(0, 400, n);
        chk("t1_done", 32'(done[0]), 32'd1);
        chk("t1_latency", 32'(n + 1), 32'd133);
        #1;
        check_xfer(0, 16);
        chk("t1_firstbit", 32'(firstbit[0]), 32'd1);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy[0]), 32'd0);

        // LSB-first 0001: first bit 1, then fifteen 0s (lands at chain top)
        do_load(1, 16'h0001, 1'b0);
        expq.push_back(rev16(16'h0001));
        wait_done(1, 400, n);
        chk("t2_done", 32'(done[1]), 32'd1);
        #1;
        check_xfer(1, 16);
        chk("t2_firstbit", 32'(firstbit[1]), 32'd1);

        // coalescing: 1111 superseded by 2222 during FFFF
        do_load(0, 16'hFFFF, 1'b1);
        repeat (20) @(negedge clk);
        do_load(0, 16'h1111, 1'b0);
        repeat (20) @(negedge clk);
        do_load(0, 16'h2222, 1'b1);
        wait_done(0, 400, n);
        chk("t3_done_a", 32'(done[0]), 32'd1);
        #1;
        check_xfer(0, 16);
        @(negedge clk);
        chk("t3_busy_between", 32'(busy[0]), 32'd1);
        wait_done(0, 400, n);
        chk("t3_done_b", 32'(done[0]), 32'd1);
        #1;
        check_xfer(0, 16);
        @(negedge clk);
        chk("t3_busy_after", 32'(busy[0]), 32'd0);

        // auto update
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy[2]) hi++;
        end
        chk("t4_idle_same", 32'(hi), 32'd0);
        din[2] = 16'h00FF;
        expq.push_back(16'h00FF);
        wait_done(2, 400, n);
        chk("t4_done", 32'(done[2]), 32'd1);
        #1;
        check_xfer(2, 16);
        hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy[2]) hi++;
        end
        chk("t4_no_retransfer", 32'(hi), 32'd0);
        chk("t4_latch_count", 32'(lat_cnt[2]), 32'(exp_lat[2]));

        // reset mid-transfer
        do_load(0, 16'hA5C3, 1'b0);
        n = 0;
        while (clk_since[0] < 6 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t5_reach_bit7", 32'(clk_since[0]), 32'd6);
        repeat (2) @(negedge clk);
        lc = lat_cnt[0];
        #2 rst0 = 1'b0;
        #1;
        chk("t5_clk",  32'(sclk[0]),  32'd0);
        chk("t5_dat",  32'(sdat[0]),  32'd0);
        chk("t5_rclk", 32'(srclk[0]), 32'd1);
        chk("t5_busy", 32'(busy[0]),  32'd0);
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("t5_no_latch", 32'(lat_cnt[0]), 32'(lc));
        do_load(0, 16'h3C5A, 1'b1);
        wait_done(0, 400, n);
        chk("t5_done", 32'(done[0]), 32'd1);
        chk("t5_latency", 32'(n + 1), 32'd133);
        #1;
        check_xfer(0, 16);

        // WIDTH=1 CLKDIV=1
        do_load(3, 16'h0001, 1'b1);
        chk("t6_c1_clk", 32'(sclk[3]), 32'd0);
        chk("t6_c1_dat", 32'(sdat[3]), 32'd1);
        @(negedge clk);
        chk("t6_c2_clk", 32'(sclk[3]), 32'd1);
        @(negedge clk);
        chk("t6_c3_clk",  32'(sclk[3]),  32'd0);
        chk("t6_c3_rclk", 32'(srclk[3]), 32'd0);
        @(negedge clk);
        chk("t6_c4_done", 32'(done[3]), 32'd1);
        #1;
        check_xfer(3, 1);
        @(negedge clk);
        chk("t6_busy_after", 32'(busy[3]), 32'd0);

        chk("sb_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
